// File: rtl/ring_slot_pkg.sv
// ---------------------------------------------------------------------------
// ring_slot_pkg
// Definitions for the one-hot time-multiplexed slot scheme. The receiving
// demultiplexer, the sending multiplexer and the scanners all import this
// package, so they agree on the slot count and the start phase.
//   RING_SLOTS  : number of slots in a frame
//   RING_INIT   : one-hot ring value for slot 0
//   ring_op_t   : action the ring counter takes on a clock edge
//   is_one_hot  : true when exactly one bit of a 4-bit ring value is set
// ---------------------------------------------------------------------------
package ring_slot_pkg;

    localparam int RING_SLOTS = 4;
    localparam logic [RING_SLOTS-1:0] RING_INIT = 4'b0001;

    typedef enum logic [1:0] {
        RING_HOLD    = 2'd0,
        RING_STEP    = 2'd1,
        RING_SYNC    = 2'd2,
        RING_CORRECT = 2'd3
    } ring_op_t;

    // Clearing the lowest set bit leaves zero only for a power of two.
    // The non-zero test rejects the all-zero ring.
    function automatic logic is_one_hot(input logic [RING_SLOTS-1:0] value);
        logic [RING_SLOTS-1:0] low_cleared;
        low_cleared = value & (value - 4'd1);
        return (value != '0) && (low_cleared == '0);
    endfunction

endpackage

// File: rtl/ring_counter_4.sv
// ---------------------------------------------------------------------------
// ring_counter_4
// One-hot 4-slot rotator with self-correction.
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous active-high reset; ring <= RING_INIT
//   step         in   rotate the ring left by one slot
//   sync         in   force the ring back to slot 0 and do not rotate
//   ring_counter out  registered one-hot slot select
//   capture      out  high when this edge's step is accepted. The parent
//                     uses it to load the slot selected by ring_counter.
//   ring_fault   out  sticky flag: the ring was seen not one-hot
// Edge priority: reset > fault correction > sync > step > hold.
// ---------------------------------------------------------------------------
module ring_counter_4
    import ring_slot_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  step,
    input  logic                  sync,
    output logic [RING_SLOTS-1:0] ring_counter,
    output logic                  capture,
    output logic                  ring_fault
);

    logic [RING_SLOTS-1:0] ring_reg;
    logic [RING_SLOTS-1:0] ring_next;
    logic                  fault_reg;
    logic                  fault_next;
    ring_op_t              ring_op;

    always_comb begin
        ring_op    = RING_HOLD;
        ring_next  = ring_reg;
        fault_next = fault_reg;
        capture    = 1'b0;

        if (!is_one_hot(ring_reg)) begin
            ring_op = RING_CORRECT;
        end else if (sync) begin
            ring_op = RING_SYNC;
        end else if (step) begin
            ring_op = RING_STEP;
        end

        case (ring_op)
            RING_CORRECT: begin
                // Step and sync are ignored on this edge. A corrupted
                // ring does not say which slot is active, so no word is
                // captured.
                ring_next  = RING_INIT;
                fault_next = 1'b1;
            end
            RING_SYNC: begin
                ring_next = RING_INIT;
            end
            RING_STEP: begin
                ring_next = {ring_reg[RING_SLOTS-2:0], ring_reg[RING_SLOTS-1]};
                capture   = 1'b1;
            end
            default: begin
                ring_next = ring_reg;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ring_reg  <= RING_INIT;
            fault_reg <= 1'b0;
        end else begin
            ring_reg  <= ring_next;
            fault_reg <= fault_next;
        end
    end

    assign ring_counter = ring_reg;
    assign ring_fault   = fault_reg;

endmodule

// File: rtl/ring_demux_1x4.sv
// ---------------------------------------------------------------------------
// ring_demux_1x4
// Receiving end of the one-hot slot scheme. On each accepted step, the word
// on data_in goes into the channel register that the ring currently selects,
// and the ring rotates. frame_done pulses for one cycle after slot 3 is
// captured. All outputs are registered.
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous active-high reset
//   step         in   capture the current slot and advance the ring
//   sync         in   restart the frame at slot 0 (no capture)
//   data_in      in   word for the currently selected slot
//   ring_counter out  one-hot slot select (can also drive the sending mux)
//   ch_3..ch_0   out  held word of each slot
//   frame_done   out  one-cycle pulse after slot 3 is captured
//   ring_fault   out  sticky flag: the ring was found not one-hot
// ---------------------------------------------------------------------------
module ring_demux_1x4
    import ring_slot_pkg::*;
#(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  step,
    input  logic                  sync,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [RING_SLOTS-1:0] ring_counter,
    output logic [DATA_WIDTH-1:0] ch_3,
    output logic [DATA_WIDTH-1:0] ch_2,
    output logic [DATA_WIDTH-1:0] ch_1,
    output logic [DATA_WIDTH-1:0] ch_0,
    output logic                  frame_done,
    output logic                  ring_fault
);

    logic                  capture;
    logic [DATA_WIDTH-1:0] ch_reg [RING_SLOTS];
    logic                  frame_done_reg;

    ring_counter_4 u_ring (
        .clock        (clock),
        .reset        (reset),
        .step         (step),
        .sync         (sync),
        .ring_counter (ring_counter),
        .capture      (capture),
        .ring_fault   (ring_fault)
    );

    // capture is high only when the ring is one-hot. The bit set in the
    // pre-rotation ring therefore selects exactly one channel.
    generate
        for (genvar gi = 0; gi < RING_SLOTS; gi++) begin : g_channel
            always_ff @(posedge clock) begin
                if (reset) begin
                    ch_reg[gi] <= '0;
                end else if (capture && ring_counter[gi]) begin
                    ch_reg[gi] <= data_in;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= capture && ring_counter[RING_SLOTS-1];
        end
    end

    assign ch_0       = ch_reg[0];
    assign ch_1       = ch_reg[1];
    assign ch_2       = ch_reg[2];
    assign ch_3       = ch_reg[3];
    assign frame_done = frame_done_reg;

endmodule
